multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle control unit for the RV32I core; replaces single-cycle opcode/funct decode with an FSM.
//  Sequences FETCH/DECODE/EXEC/MEM/WB over a shared datapath and handshakes with instruction/data memory.
//  Adds memory wait states, an ack timeout, and a sticky trap on illegal opcode or timeout.
// PARAMETERS
//  TIMEOUT   16  max cycles a req may wait for ack before trap (>=2)
//  CNT_W     32  width of performance counters
//  ALU_CC_W  4   width of alu_cc
// PORTS
//  clk          in   1         system clock
//  reset        in   1         asynchronous, active-low reset
//  opcode       in   7         IR[6:0] from datapath instruction register
//  funct3       in   3         IR[14:12]
//  funct7       in   7         IR[31:25]
//  zero         in   1         ALU zero flag (branch compare)
//  imem_req     out  1         instruction fetch request, held until imem_ack
//  imem_ack     in   1         fetch data valid; may be high in the same cycle as req
//  dmem_req     out  1         data access request, held until dmem_ack
//  dmem_ack     in   1         data access complete
//  ir_write     out  1         load IR (pulse on fetch ack)
//  pc_write     out  1         PC <= PC+4 (fetch ack) or branch target (taken BEQ)
//  pc_src       out  1         0: PC+4, 1: branch target
//  alu_src      out  1         0: rs2, 1: immediate
//  alu_cc       out  ALU_CC_W  ALU operation
//  mem_read     out  1         dmem read (with dmem_req)
//  mem_write    out  1         dmem write (with dmem_req)
//  mem2reg      out  1         writeback source: 0 ALU, 1 memory
//  reg_write    out  1         register file write enable
//  trap         out  1         sticky error flag
//  trap_cause   out  2         0 none, 1 illegal opcode, 2 imem timeout, 3 dmem timeout
//  cycle_cnt    out  CNT_W     cycles since reset (feature-gated)
//  instret_cnt  out  CNT_W     retired instructions (feature-gated)
// BEHAVIOUR
//  - States: IDLE, FETCH, DECODE, EXEC, ADDR, MEM, WB, BRANCH, TRAP. Reset -> IDLE; all outputs 0, counters 0.
//  - Outputs are Moore (state + IR fields only); none depend combinationally on ack except ir_write/pc_write in FETCH.
//  - IDLE->FETCH unconditionally. FETCH: imem_req=1; on imem_ack: ir_write=1, pc_write=1, pc_src=0, ->DECODE.
//  - DECODE: R(0110011)/I(0010011)->EXEC; LW(0000011)/SW(0100011)->ADDR; BEQ(1100011)->BRANCH; else ->TRAP cause 1.
//  - EXEC: alu_src=(I-type), alu_cc from funct ->WB. WB: reg_write=1 (mem2reg=1 if LW) ->FETCH.
//  - ADDR: alu_src=1, alu_cc=ADD ->MEM. MEM: dmem_req=1, mem_read(LW)/mem_write(SW); on dmem_ack LW->WB, SW->FETCH.
//  - BRANCH: alu_cc=SUB; if zero: pc_write=1, pc_src=1. ->FETCH.
//  - Latency (zero-wait ack): R/I 4, LW 5, SW 4, BEQ 3 cycles; each wait cycle adds 1.
//  - alu_cc: ADD 0010, SUB 0110 (funct7[5]=1, R only), AND 0000, OR 0001, XOR 0011, SLT 0111; other funct3 -> TRAP cause 1.
//  - Timeout: wait counter clears on state entry, increments each cycle req is high without ack;
//    reaching TIMEOUT-1 with no ack -> TRAP (cause 2/3). Ack on that same cycle wins (no trap).
//  - TRAP: all controls 0, trap=1, cause held; exits only by reset. Mid-operation reset aborts to IDLE.
// CONFIGURATION
//  MCTRL_PERF_EN defined: cycle_cnt +1 every non-IDLE cycle; instret_cnt +1 on WB, SW ack, BRANCH exit; both wrap at 2^CNT_W.
//  Not defined: counter logic absent, cycle_cnt/instret_cnt tied to 0; ports remain.
// STRUCTURE
//  mctrl_pkg: state enum, opcode constants, alu_cc constants, trap cause codes.
//  Sub-module mctrl_alu_decode: combinational (state, opcode, funct3, funct7) -> alu_cc, illegal flag.
// TESTING
//  1. ADD (R, funct7=0, f3=0), acks same cycle -> alu_cc=0010 in EXEC, reg_write in cycle 4, instret=1.
//  2. LW with dmem_ack after 3 wait cycles -> MEM held 4 cycles, mem2reg=1 & reg_write in WB, total 8 cycles.
//  3. BEQ zero=1 -> pc_write=1,pc_src=1 in BRANCH; zero=0 -> pc_write=0; both 3 cycles.
//  4. opcode 1111111 -> trap=1, cause=1, all controls 0 until reset, counters frozen.
//  5. imem_ack never arrives, TIMEOUT=16 -> trap cause 2 after 16 FETCH cycles; ack on 16th -> no trap.
//  6. reset asserted in MEM (dmem_req=1) -> outputs 0 immediately; after release IDLE then FETCH.

Source files
------------

// File: rtl/mctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit:
// FSM state enum, opcode constants, ALU operation codes and trap causes.
package mctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_ADDR,
    S_MEM,
    S_WB,
    S_BRANCH,
    S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_IMEM_TO = 2'd2,
    CAUSE_DMEM_TO = 2'd3
  } cause_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

endpackage

// File: rtl/mctrl_alu_decode.sv
// Combinational ALU-operation decode. Produces alu_cc for the EXEC, ADDR
// and BRANCH states and flags instructions the core cannot execute while
// the FSM sits in DECODE.
module mctrl_alu_decode
  import mctrl_pkg::*;
(
  input  state_t     state,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_cc,
  output logic       illegal
);

  logic [3:0] funct_cc;
  logic       funct_ok;

  // Map funct3/funct7 of an R/I instruction to an ALU operation.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    funct_cc = ALU_ADD;
    funct_ok = 1'b1;
    case (funct3)
      3'b000:  funct_cc = (opcode == OP_R && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b111:  funct_cc = ALU_AND;
      3'b110:  funct_cc = ALU_OR;
      3'b100:  funct_cc = ALU_XOR;
      3'b010:  funct_cc = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
    // R-type only knows funct7 = 0, plus 0100000 for SUB; I-type funct7 is immediate.
    if (opcode == OP_R &&
        !(funct7 == 7'b0000000 || (funct7 == 7'b0100000 && funct3 == 3'b000)))
      funct_ok = 1'b0;
  end

  // Select the ALU operation per state and raise illegal for unknown encodings.
  always_comb begin
    alu_cc  = ALU_AND;
    illegal = 1'b0;
    case (state)
      S_DECODE: begin
        case (opcode)
          OP_R, OP_I:            illegal = !funct_ok;
          OP_LW, OP_SW, OP_BEQ:  illegal = 1'b0;
          default:               illegal = 1'b1;
        endcase
      end
      S_EXEC:   alu_cc = funct_cc;
      S_ADDR:   alu_cc = ALU_ADD;
      S_BRANCH: alu_cc = ALU_SUB;
      default:  alu_cc = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the RV32I core. Sequences FETCH/DECODE/EXEC/
// ADDR/MEM/WB/BRANCH over a shared datapath, handshakes with instruction and
// data memory, times out stalled requests and latches a sticky trap.
// Optional performance counters are built when MCTRL_PERF_EN is defined;
// otherwise cycle_cnt and instret_cnt are tied to zero.
module multicycle_control #(
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 32,
  parameter int ALU_CC_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                zero,
  output logic                imem_req,
  input  logic                imem_ack,
  output logic                dmem_req,
  input  logic                dmem_ack,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                alu_src,
  output logic [ALU_CC_W-1:0] alu_cc,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem2reg,
  output logic                reg_write,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    instret_cnt
);

  import mctrl_pkg::*;

  localparam int WAIT_W = $clog2(TIMEOUT);

  state_t             state, state_next;
  cause_t             cause_q, trap_code;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [3:0]         alu_cc_dec;
  logic               illegal;
  logic               wait_hit;
  logic               is_lw, is_sw;

  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign wait_hit = (wait_cnt == WAIT_W'(TIMEOUT - 1));

  mctrl_alu_decode u_alu_decode (
    .state   (state),
    .opcode  (opcode),
    .funct3  (funct3),
    .funct7  (funct7),
    .alu_cc  (alu_cc_dec),
    .illegal (illegal)
  );

  assign alu_cc     = ALU_CC_W'(alu_cc_dec);
  assign trap_cause = cause_q;

  // State register; an asserted reset aborts any operation back to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state and Moore control outputs; only ir_write/pc_write in FETCH follow imem_ack.
  always_comb begin
    state_next = state;
    trap_code  = CAUSE_NONE;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem2reg    = 1'b0;
    reg_write  = 1'b0;
    trap       = 1'b0;
    case (state)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end else if (wait_hit) begin
          state_next = S_TRAP;
          trap_code  = CAUSE_IMEM_TO;
        end
      end
      S_DECODE: begin
        if (illegal) begin
          state_next = S_TRAP;
          trap_code  = CAUSE_ILLEGAL;
        end else begin
          case (opcode)
            OP_R, OP_I:   state_next = S_EXEC;
            OP_LW, OP_SW: state_next = S_ADDR;
            OP_BEQ:       state_next = S_BRANCH;
            default: begin
              state_next = S_TRAP;
              trap_code  = CAUSE_ILLEGAL;
            end
          endcase
        end
      end
      S_EXEC: begin
        alu_src    = (opcode == OP_I);
        state_next = S_WB;
      end
      S_ADDR: begin
        alu_src    = 1'b1;
        state_next = S_MEM;
      end
      S_MEM: begin
        dmem_req  = 1'b1;
        mem_read  = is_lw;
        mem_write = is_sw;
        if (dmem_ack) begin
          state_next = is_lw ? S_WB : S_FETCH;
        end else if (wait_hit) begin
          state_next = S_TRAP;
          trap_code  = CAUSE_DMEM_TO;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem2reg    = is_lw;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        pc_write   = zero;
        pc_src     = zero;
        state_next = S_FETCH;
      end
      S_TRAP:  trap = 1'b1;
      default: state_next = S_IDLE;
    endcase
  end

  // Request wait counter: restarts on every state entry, counts stalled request cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    wait_cnt <= '0;
    else if (state_next != state)  wait_cnt <= '0;
    else if (imem_req || dmem_req) wait_cnt <= wait_cnt + 1'b1;
  end

  // Trap cause is captured once on TRAP entry and held until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                       cause_q <= CAUSE_NONE;
    else if (state != S_TRAP && state_next == S_TRAP) cause_q <= trap_code;
  end

`ifdef MCTRL_PERF_EN
  logic retire;

  assign retire = (state == S_WB) || (state == S_BRANCH) ||
                  (state == S_MEM && dmem_ack && is_sw);

  // Performance counters; both freeze once trapped and wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != S_IDLE && state != S_TRAP) cycle_cnt <= cycle_cnt + 1'b1;
      if (retire)                             instret_cnt <= instret_cnt + 1'b1;
    end
  end
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control. Each task resets the
// DUT, drives a per-cycle stimulus pattern and compares the packed control
// outputs against hand-derived expectations, one cycle at a time.
module tb_multicycle_control;

`ifdef MCTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // Packed observation: {imem_req,dmem_req,ir_write,pc_write,pc_src,alu_src,
  //  mem_read,mem_write,mem2reg,reg_write,trap,trap_cause[1:0],alu_cc[3:0]}
  localparam logic [16:0] E_IREQ   = 17'h10000;
  localparam logic [16:0] E_DREQ   = 17'h08000;
  localparam logic [16:0] E_IRW    = 17'h04000;
  localparam logic [16:0] E_PCW    = 17'h02000;
  localparam logic [16:0] E_PCSRC  = 17'h01000;
  localparam logic [16:0] E_ALUSRC = 17'h00800;
  localparam logic [16:0] E_MRD    = 17'h00400;
  localparam logic [16:0] E_MWR    = 17'h00200;
  localparam logic [16:0] E_M2R    = 17'h00100;
  localparam logic [16:0] E_RW     = 17'h00080;
  localparam logic [16:0] E_TRAP   = 17'h00040;
  localparam logic [16:0] C_ILL    = 17'h00010;
  localparam logic [16:0] C_IMEM   = 17'h00020;
  localparam logic [16:0] C_DMEM   = 17'h00030;
  localparam logic [16:0] A_ADD    = 17'h00002;
  localparam logic [16:0] A_SUB    = 17'h00006;
  localparam logic [16:0] A_XOR    = 17'h00003;
  localparam logic [16:0] E_FACK   = E_IREQ | E_IRW | E_PCW;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic        zero = 1'b0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        imem_req, dmem_req, ir_write, pc_write, pc_src, alu_src;
  logic        mem_read, mem_write, mem2reg, reg_write, trap;
  logic [3:0]  alu_cc;
  logic [1:0]  trap_cause;
  logic [31:0] cycle_cnt, instret_cnt;
  logic [16:0] obs;

  int n_checks = 0;
  int n_fails  = 0;

  multicycle_control #(.TIMEOUT(16), .CNT_W(32), .ALU_CC_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .zero        (zero),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .dmem_req    (dmem_req),
    .dmem_ack    (dmem_ack),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .alu_src     (alu_src),
    .alu_cc      (alu_cc),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem2reg     (mem2reg),
    .reg_write   (reg_write),
    .trap        (trap),
    .trap_cause  (trap_cause),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {imem_req, dmem_req, ir_write, pc_write, pc_src, alu_src,
                mem_read, mem_write, mem2reg, reg_write, trap, trap_cause, alu_cc};

  // Hold reset for two cycles and release at a falling edge: the DUT is then in IDLE.
  task automatic do_reset();
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    zero     = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (obs !== 17'h0) begin
      n_fails++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 17'h0);
    end
    n_checks++;
    if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
      n_fails++;
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", cycle_cnt, instret_cnt);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    logic [16:0] exp [6];
    exp = '{17'h0, E_FACK, 17'h0, A_ADD, E_RW, E_FACK};
    do_reset();
    opcode = OP_R; funct3 = 3'b000; funct7 = 7'b0000000; imem_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++;
      if (obs !== exp[i]) begin
        n_fails++;
        $display("FAIL add cycle %0d: got %h expected %h", i, obs, exp[i]);
      end
      if (i < 5) @(negedge clk);
    end
    n_checks++;
    if (cycle_cnt !== 32'(PERF ? 4 : 0) || instret_cnt !== 32'(PERF ? 1 : 0)) begin
      n_fails++;
      $display("FAIL add_counters: got %0d/%0d expected %0d/%0d",
               cycle_cnt, instret_cnt, PERF ? 4 : 0, PERF ? 1 : 0);
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp [10];
    exp = '{17'h0, E_FACK, 17'h0, A_SUB, E_RW,
            E_FACK, 17'h0, E_ALUSRC | A_XOR, E_RW, E_FACK};
    do_reset();
    opcode = OP_R; funct3 = 3'b000; funct7 = 7'b0100000; imem_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        opcode = OP_I; funct3 = 3'b100; funct7 = 7'b0100000;
      end
      #1;
      n_checks++;
      if (obs !== exp[i]) begin
        n_fails++;
        $display("FAIL sub_xori cycle %0d: got %h expected %h", i, obs, exp[i]);
      end
      if (i < 9) @(negedge clk);
    end
    n_checks++;
    if (cycle_cnt !== 32'(PERF ? 8 : 0) || instret_cnt !== 32'(PERF ? 2 : 0)) begin
      n_fails++;
      $display("FAIL sub_xori_counters: got %0d/%0d", cycle_cnt, instret_cnt);
    end
  endtask

  task automatic test_lw_wait();
    logic [16:0] exp [10];
    exp = '{17'h0, E_FACK, 17'h0, E_ALUSRC | A_ADD, E_DREQ | E_MRD, E_DREQ | E_MRD,
            E_DREQ | E_MRD, E_DREQ | E_MRD, E_RW | E_M2R, E_FACK};
    do_reset();
    opcode = OP_LW; funct3 = 3'b010; funct7 = 7'b0; imem_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      dmem_ack = (i == 7);
      #1;
      n_checks++;
      if (obs !== exp[i]) begin
        n_fails++;
        $display("FAIL lw_wait cycle %0d: got %h expected %h", i, obs, exp[i]);
      end
      if (i < 9) @(negedge clk);
    end
    n_checks++;
    if (cycle_cnt !== 32'(PERF ? 8 : 0) || instret_cnt !== 32'(PERF ? 1 : 0)) begin
      n_fails++;
      $display("FAIL lw_counters: got %0d/%0d", cycle_cnt, instret_cnt);
    end
  endtask

  task automatic test_sw();
    logic [16:0] exp [6];
    exp = '{17'h0, E_FACK, 17'h0, E_ALUSRC | A_ADD, E_DREQ | E_MWR, E_FACK};
    do_reset();
    opcode = OP_SW; funct3 = 3'b010; funct7 = 7'b0; imem_ack = 1'b1; dmem_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++;
      if (obs !== exp[i]) begin
        n_fails++;
        $display("FAIL sw cycle %0d: got %h expected %h", i, obs, exp[i]);
      end
      if (i < 5) @(negedge clk);
    end
    n_checks++;
    if (cycle_cnt !== 32'(PERF ? 4 : 0) || instret_cnt !== 32'(PERF ? 1 : 0)) begin
      n_fails++;
      $display("FAIL sw_counters: got %0d/%0d", cycle_cnt, instret_cnt);
    end
  endtask

  task automatic test_beq();
    logic [16:0] exp [8];
    exp = '{17'h0, E_FACK, 17'h0, A_SUB | E_PCW | E_PCSRC,
            E_FACK, 17'h0, A_SUB, E_FACK};
    do_reset();
    opcode = OP_BEQ; funct3 = 3'b000; funct7 = 7'b0; imem_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      zero = (i <= 3);
      #1;
      n_checks++;
      if (obs !== exp[i]) begin
        n_fails++;
        $display("FAIL beq cycle %0d: got %h expected %h", i, obs, exp[i]);
      end
      if (i < 7) @(negedge clk);
    end
    n_checks++;
    if (cycle_cnt !== 32'(PERF ? 6 : 0) || instret_cnt !== 32'(PERF ? 2 : 0)) begin
      n_fails++;
      $display("FAIL beq_counters: got %0d/%0d", cycle_cnt, instret_cnt);
    end
  endtask

  task automatic test_illegal();
    logic [16:0] exp [8];
    exp = '{17'h0, E_FACK, 17'h0, E_TRAP | C_ILL, E_TRAP | C_ILL,
            E_TRAP | C_ILL, E_TRAP | C_ILL, E_TRAP | C_ILL};
    do_reset();
    opcode = 7'b1111111; funct3 = 3'b000; funct7 = 7'b0; imem_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dmem_ack = (i >= 3) && (i % 2 == 1);
      zero     = (i >= 3);
      #1;
      n_checks++;
      if (obs !== exp[i]) begin
        n_fails++;
        $display("FAIL illegal_op cycle %0d: got %h expected %h", i, obs, exp[i]);
      end
      if (i == 3 || i == 7) begin
        n_checks++;
        if (cycle_cnt !== 32'(PERF ? 2 : 0) || instret_cnt !== 32'd0) begin
          n_fails++;
          $display("FAIL illegal_counters cycle %0d: got %0d/%0d", i, cycle_cnt, instret_cnt);
        end
      end
      if (i < 7) @(negedge clk);
    end
    // R-type with an unsupported funct3 (SLL) also traps as illegal.
    do_reset();
    opcode = OP_R; funct3 = 3'b001; funct7 = 7'b0; imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (i == 3) begin
        n_checks++;
        if (obs !== (E_TRAP | C_ILL)) begin
          n_fails++;
          $display("FAIL illegal_funct3: got %h expected %h", obs, E_TRAP | C_ILL);
        end
      end
      if (i < 3) @(negedge clk);
    end
  endtask

  task automatic test_fetch_timeout();
    logic [16:0] e;
    do_reset();
    opcode = OP_R; funct3 = 3'b000; funct7 = 7'b0; imem_ack = 1'b0;
    for (int i = 0; i < 19; i++) begin
      e = (i == 0) ? 17'h0 : (i <= 16) ? E_IREQ : (E_TRAP | C_IMEM);
      #1;
      n_checks++;
      if (obs !== e) begin
        n_fails++;
        $display("FAIL imem_timeout cycle %0d: got %h expected %h", i, obs, e);
      end
      if (i < 18) @(negedge clk);
    end
  endtask

  task automatic test_ack_on_last();
    logic [16:0] e;
    do_reset();
    opcode = OP_R; funct3 = 3'b000; funct7 = 7'b0;
    for (int i = 0; i < 19; i++) begin
      imem_ack = (i == 16);
      e = (i == 0) ? 17'h0 : (i <= 15) ? E_IREQ : (i == 16) ? E_FACK :
          (i == 17) ? 17'h0 : A_ADD;
      #1;
      n_checks++;
      if (obs !== e) begin
        n_fails++;
        $display("FAIL imem_ack_last cycle %0d: got %h expected %h", i, obs, e);
      end
      if (i < 18) @(negedge clk);
    end
  endtask

  task automatic test_dmem_timeout();
    logic [16:0] e;
    do_reset();
    opcode = OP_SW; funct3 = 3'b010; funct7 = 7'b0; imem_ack = 1'b1; dmem_ack = 1'b0;
    for (int i = 0; i < 21; i++) begin
      e = (i == 0) ? 17'h0 : (i == 1) ? E_FACK : (i == 2) ? 17'h0 :
          (i == 3) ? (E_ALUSRC | A_ADD) : (i <= 19) ? (E_DREQ | E_MWR) : (E_TRAP | C_DMEM);
      #1;
      n_checks++;
      if (obs !== e) begin
        n_fails++;
        $display("FAIL dmem_timeout cycle %0d: got %h expected %h", i, obs, e);
      end
      if (i < 20) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    opcode = OP_LW; funct3 = 3'b010; funct7 = 7'b0; imem_ack = 1'b1; dmem_ack = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    n_checks++;
    if (obs !== (E_DREQ | E_MRD)) begin
      n_fails++;
      $display("FAIL mid_mem_before_reset: got %h expected %h", obs, E_DREQ | E_MRD);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (obs !== 17'h0 || cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
      n_fails++;
      $display("FAIL mid_mem_async_reset: got %h/%0d/%0d expected 0/0/0",
               obs, cycle_cnt, instret_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (obs !== 17'h0) begin
      n_fails++;
      $display("FAIL mid_mem_idle: got %h expected %h", obs, 17'h0);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (obs !== E_FACK) begin
      n_fails++;
      $display("FAIL mid_mem_refetch: got %h expected %h", obs, E_FACK);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_lw_wait();
    test_sw();
    test_beq();
    test_illegal();
    test_fetch_timeout();
    test_ack_on_last();
    test_dmem_timeout();
    test_reset_mid_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
